data_memory_hs: RTL

Parametrised, handshaked data memory that replaces the fixed 32×32 data store in the single-cycle datapath. It provides byte-addressed, byte-strobed word access with a valid/ready request/response protocol, a single-cycle registered read, and range and alignment checking. After every reset, a sequential init sweep preloads every word with its own index before the memory accepts traffic.

---
 rtl/data_memory_hs.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/data_memory_hs.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | data_memory_hs: byte-strobed word memory, valid/ready access, init sweep  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module data_memory_hs #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [DATA_W/8-1:0]   req_wstrb,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_W-1:0]     resp_rdata,
  output logic                  resp_err,
  output logic                  init_done
);

  localparam int BYTES = DATA_W / 8;
  localparam int OFF_W = (BYTES > 1) ? $clog2(BYTES) : 0;
  localparam int IDX_W = $clog2(DEPTH);

  localparam logic [1:0] ST_INIT = 2'd0;
  localparam logic [1:0] ST_IDLE = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [ADDR_W-1:0] DEPTH_A  = ADDR_W'(DEPTH);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DEPTH - 1);

  logic [1:0]        state_q, state_d;
  logic [IDX_W-1:0]  init_ptr_q, init_ptr_d;
  logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
  logic              resp_err_q, resp_err_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [ADDR_W-1:0] w_word_addr;
  logic [IDX_W-1:0]  w_idx;
  logic              w_misaligned;
  logic              w_out_of_range;
  logic              w_bad;
  logic              w_init_we;
  logic              w_wr_en;

  // Full word address is compared so that any set upper bit counts as out of range
  assign w_word_addr    = req_addr >> OFF_W;
  assign w_idx          = w_word_addr[IDX_W-1:0];
  assign w_out_of_range = (w_word_addr >= DEPTH_A);
  assign w_bad          = w_misaligned | w_out_of_range;

  generate
    if (OFF_W == 0) begin : g_no_offset
      assign w_misaligned = 1'b0;
    end else begin : g_offset
      assign w_misaligned = |req_addr[OFF_W-1:0];
    end
  endgenerate

  assign w_init_we = (state_q == ST_INIT);
  assign w_wr_en   = (state_q == ST_IDLE) && req_valid && req_write && !w_bad;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_INIT;
      init_ptr_q   <= '0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      init_ptr_q   <= init_ptr_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    init_ptr_d   = init_ptr_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    case (state_q)
      ST_INIT: begin
        init_ptr_d = init_ptr_q + 1'b1;
        if (init_ptr_q == LAST_IDX) begin
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (req_valid) begin
          state_d      = ST_RESP;
          resp_err_d   = w_bad;
          resp_rdata_d = (w_bad || req_write) ? '0 : mem_q[w_idx];
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    init_done  = 1'b1;
    case (state_q)
      ST_INIT: init_done  = 1'b0;
      ST_IDLE: req_ready  = 1'b1;
      ST_RESP: resp_valid = 1'b1;
      default: init_done  = 1'b0;
    endcase
  end

  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

  // Storage is never cleared by reset; the init sweep rewrites every word
  always_ff @(posedge clk) begin
    if (reset) begin
      if (w_init_we) begin
        mem_q[init_ptr_q] <= DATA_W'(init_ptr_q);
      end else if (w_wr_en) begin
        for (int k = 0; k < BYTES; k++) begin
          if (req_wstrb[k]) begin
            mem_q[w_idx][8*k +: 8] <= req_wdata[8*k +: 8];
          end
        end
      end
    end
  end

endmodule
`default_nettype wire
